// File: rtl/stu_violation_tracker.sv
// Speculative read-set tracker: records spec-core load lines during an L2 task and
// flags a sticky violation when a master-core store hits the set or the set overflows.
module stu_violation_tracker #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned LINE_OFF = 6,
   parameter int unsigned ENTRIES  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           task_start_in,
   input  logic                           task_active_in,
   input  logic                           squash_in,
   input  logic                           commit_in,
   input  logic                           spec_load_valid_in,
   input  logic [ADDR_W-1:0]              spec_load_addr_in,
   input  logic                           master_store_valid_in,
   input  logic [ADDR_W-1:0]              master_store_addr_in,
   output logic                           violation_out,
   output logic                           overflow_out,
   output logic                           armed_out,
   output logic [$clog2(ENTRIES+1)-1:0]   occupancy_out
);

   localparam int unsigned TAG_W = ADDR_W - LINE_OFF;
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRACK    = 2'd1,
      VIOLATED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q [ENTRIES];
   logic                viol_q, viol_d;
   logic                ovf_q, ovf_d;
   logic                armed_q, armed_d;
   logic [OCC_W-1:0]    occ_q, occ_d;

   logic [TAG_W-1:0]    load_line, store_line;
   logic                load_hit, store_hit_c, free_found, overflow_c, clear_c;
   logic [IDX_W-1:0]    free_idx;
   logic                alloc_en;
   logic [IDX_W-1:0]    alloc_idx;
   logic                unused_offset_bits;

   assign load_line  = spec_load_addr_in[ADDR_W-1:LINE_OFF];
   assign store_line = master_store_addr_in[ADDR_W-1:LINE_OFF];
   assign unused_offset_bits = ^{spec_load_addr_in[LINE_OFF-1:0], master_store_addr_in[LINE_OFF-1:0]};

   assign clear_c = squash_in | commit_in | (armed_q & ~task_active_in);

   // Associative lookups and lowest-index free-entry search
   always_comb begin
      load_hit    = 1'b0;
      store_hit_c = 1'b0;
      free_found  = 1'b0;
      free_idx    = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[IDX_W'(i)] && tag_q[IDX_W'(i)] == load_line)  load_hit    = 1'b1;
         if (valid_q[IDX_W'(i)] && tag_q[IDX_W'(i)] == store_line) store_hit_c = 1'b1;
      end
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (!valid_q[IDX_W'(i)]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      // A same-cycle load counts as already read by the store check
      if (spec_load_valid_in && load_line == store_line) store_hit_c = 1'b1;
      store_hit_c = store_hit_c & master_store_valid_in;
   end

   assign overflow_c = spec_load_valid_in & ~load_hit & ~free_found;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (task_start_in)
         state_d = TRACK;
      else if (clear_c)
         state_d = IDLE;
      else if (state_q == TRACK && (overflow_c || store_hit_c))
         state_d = VIOLATED;
   end

   // Output / read-set next values
   always_comb begin
      valid_d   = valid_q;
      viol_d    = viol_q;
      ovf_d     = ovf_q;
      occ_d     = occ_q;
      alloc_en  = 1'b0;
      alloc_idx = '0;
      armed_d   = (state_d != IDLE);
      if (task_start_in) begin
         valid_d = '0;
         viol_d  = 1'b0;
         ovf_d   = 1'b0;
         occ_d   = '0;
         if (spec_load_valid_in) begin
            valid_d[0] = 1'b1;
            occ_d      = OCC_W'(1);
            alloc_en   = 1'b1;
         end
      end else if (clear_c) begin
         valid_d = '0;
         viol_d  = 1'b0;
         ovf_d   = 1'b0;
         occ_d   = '0;
      end else if (state_q == TRACK) begin
         if (spec_load_valid_in && !load_hit) begin
            if (free_found) begin
               valid_d[free_idx] = 1'b1;
               occ_d             = occ_q + OCC_W'(1);
               alloc_en          = 1'b1;
               alloc_idx         = free_idx;
            end else begin
               viol_d = 1'b1;
               ovf_d  = 1'b1;
            end
         end
         if (store_hit_c) viol_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         viol_q  <= 1'b0;
         ovf_q   <= 1'b0;
         armed_q <= 1'b0;
         occ_q   <= '0;
      end else begin
         valid_q <= valid_d;
         viol_q  <= viol_d;
         ovf_q   <= ovf_d;
         armed_q <= armed_d;
         occ_q   <= occ_d;
      end
   end

   // Tags are only meaningful under their valid bit, so they need no reset
   always_ff @(posedge clk) begin
      if (alloc_en) tag_q[alloc_idx] <= load_line;
   end

   assign violation_out = viol_q;
   assign overflow_out  = ovf_q;
   assign armed_out     = armed_q;
   assign occupancy_out = occ_q;

endmodule

// File: doc/stu_violation_tracker.md
Name: stu_violation_tracker

Overview:
- Upstream neighbour of the L2 validator.
- Records the cache lines read by the speculative core during an active Level-2 task in a small fully-associative read set.
- Checks every master-core store line against that set and raises a sticky violation_out, which feeds the validator's violation input.
- Read-set overflow is treated conservatively as a violation.

Parameters:
ADDR_W, 32, byte address width of load/store ports
LINE_OFF, 6, log2 line size in bytes; lines compared on addr[ADDR_W-1:LINE_OFF]
ENTRIES, 16, read-set capacity (>=2)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
task_start_in  in  1  pulse: new L2 task forked; clears set and arms tracker
task_active_in  in  1  level: L2 task alive (same signal the validator sees)
squash_in  in  1  validator squash pulse
commit_in  in  1  validator commit pulse
spec_load_valid_in  in  1  speculative core load retired
spec_load_addr_in  in  ADDR_W  its byte address
master_store_valid_in  in  1  master core store retired
master_store_addr_in  in  ADDR_W  its byte address
violation_out  out  1  sticky registered violation flag
overflow_out  out  1  sticky: violation caused by read-set overflow
armed_out  out  1  1 in TRACK or VIOLATED
occupancy_out  out  $clog2(ENTRIES+1)  number of valid read-set entries

Behaviour:
- Reset (rst=0, async): state IDLE, all entry valid bits 0, violation_out=0, overflow_out=0, armed_out=0, occupancy_out=0.
- States:
  - IDLE: all inputs ignored except task_start_in.
  - TRACK: record loads, check stores.
  - VIOLATED: frozen. No recording. violation_out held at 1.
- Clear event = squash_in | commit_in | (armed & !task_active_in).
  - Any state -> IDLE next cycle.
  - Invalidates all entries; clears violation_out and overflow_out.
  - Same-cycle loads and stores are ignored.
- Transition on task_start_in=1:
  - Any state -> TRACK. Start has priority over a clear event.
  - Set is cleared; violation_out and overflow_out are cleared.
  - A same-cycle spec load is recorded as the sole entry.
  - A same-cycle master store is ignored.
- TRACK, load recording (spec_load_valid_in=1):
  - line = addr[ADDR_W-1:LINE_OFF].
  - If line already present: no change (no duplicates).
  - Else, if a free entry exists: allocate the lowest-index free entry; occupancy +1 next cycle.
  - Else: overflow. Next cycle violation_out=1, overflow_out=1, state VIOLATED.
- TRACK, store check (master_store_valid_in=1):
  - Store line is compared against all valid entries and also against a same-cycle spec load line (conservative bypass).
  - On any match: next cycle violation_out=1, state VIOLATED, overflow_out stays 0.
- Latency: violation_out rises exactly 1 cycle after the offending store/load cycle. No combinational path from inputs to any output.
- Load and store in the same cycle with different lines: load recorded, no violation.
- Overflow and store match in the same cycle: violation_out=1, overflow_out=1.
- occupancy_out saturates at ENTRIES and never wraps; holds its value in VIOLATED.
- armed_out = (state != IDLE), registered.

Test Plan:
- Reset mid-TRACK with 3 entries valid and violation_out=1 -> all outputs 0 immediately (async), state IDLE after release.
- Start; loads 0x1000, 0x1004, 0x2040 -> occupancy_out=2 (0x1000 and 0x1004 share a line); store 0x3000 -> no violation; store 0x203C -> no violation (line 0x2000 differs from 0x2040); store 0x2050 -> violation_out=1 next cycle, overflow_out=0.
- Start; load 0x4000 and store 0x4010 in the same cycle -> violation_out=1 next cycle (bypass match).
- Start with ENTRIES=16; 16 distinct-line loads -> occupancy_out=16, no violation; 17th distinct line -> violation_out=1, overflow_out=1; further loads leave occupancy_out at 16.
- While VIOLATED, pulse squash_in -> next cycle violation_out=0, armed_out=0, occupancy_out=0; a subsequent store 0x2050 -> no violation (IDLE).
- In TRACK with 2 entries, drop task_active_in -> IDLE and cleared next cycle. In a separate sequence, task_start_in and commit_in in the same cycle with load 0x8000 -> TRACK, occupancy_out=1.
